gecko_writeback: RTL and testbench
==================================

# gecko_writeback

Writeback stage of the gecko core. Accepts completed results from the execute, memory-load and system units and arbitrates them onto the single register-file write port. Owns the per-register pending-write scoreboard: decode reserves a destination at issue, and writeback releases it at retire. Exports the per-register status vector that decode uses for its operand-readiness and destination-writeability checks.

## Interface
Parameters:
- `COUNTER_WIDTH`, default 2: width of each per-register pending counter; equals the width of `gecko_reg_status_t`.

Ports:
- `clk` input 1: core clock.
- `rst` input 1: synchronous, active-high reset.
- `issue_valid` input 1: decode issued an instruction that writes back.
- `issue_reg_addr` input 5: rd of that instruction (`rv32_reg_addr_t`).
- `exec_valid` input 1 / `exec_ready` output 1 / `exec_result` input 37: execute result (`gecko_writeback_result_t`).
- `mem_valid` input 1 / `mem_ready` output 1 / `mem_result` input 37: load result.
- `sys_valid` input 1 / `sys_ready` output 1 / `sys_result` input 37: CSR result.
- `rf_write_enable` output 1: register-file write strobe.
- `rf_write_addr` output 5: write address.
- `rf_write_value` output 32: write data.
- `reg_status` output 32×COUNTER_WIDTH: `gecko_decode_reg_file_status_t`, one entry per register.
- `scoreboard_error` output 1: sticky protocol-violation flag.

## Operation
- **Counters:** one COUNTER_WIDTH-bit counter per register.
  - `reg_status[i]` is the counter value.
  - 0 = `GECKO_REG_STATUS_VALID`; all-ones = `GECKO_REG_STATUS_FULL`; intermediate values = pending.
- **Issue:** `issue_valid` with `issue_reg_addr != 0` increments that counter. Issue to x0 is ignored.
- **Arbitration:** fixed priority mem > sys > exec.
  - `mem_ready = 1`.
  - `sys_ready = !mem_valid`.
  - `exec_ready = !mem_valid && !sys_valid`.
  - Ready depends only on higher-priority valids, never on the requester's own valid.
  - At most one transfer per cycle.
- **Retire:** a transfer (valid && ready) with `reg_addr != 0` decrements that counter and writes the register file. A transfer to x0 is accepted and consumed, with no write and no decrement.
- **Simultaneous issue and retire:**
  - Same register: counter unchanged.
  - Different registers: each is updated independently.
- **Saturation:** the counter never wraps.
  - Issue to a FULL counter is dropped and sets `scoreboard_error`.
  - Retire to a counter at 0 is dropped (no write, no decrement) and sets `scoreboard_error`.
  - The same-register issue+retire case never errors.
- `scoreboard_error` stays set until `rst`.
- Decode is responsible for never issuing to a FULL register (`is_register_writeable`).

## Timing
- **Transfer to write:** a transfer in cycle N gives `rf_write_enable=1`, `rf_write_addr` and `rf_write_value` in cycle N+1 (registered outputs).
- **Issue to status:** issue in cycle N updates `reg_status` in cycle N+1.
- **Retire to status:** the decrement also becomes visible in N+1, coincident with `rf_write_enable`.
- The register file must forward write-port data to same-cycle reads, so VALID status always matches readable data.
- `rf_write_enable` is 0 in any cycle not preceded by a non-x0 transfer.
- **Reset values:** all counters 0 (all registers VALID), `rf_write_enable=0`, `rf_write_addr=0`, `rf_write_value=0`, `scoreboard_error=0`.
- Ready outputs are combinational and follow the valids even during reset.
- **Reset mid-operation:** in-flight writes are discarded, the cycle after `rst` shows no write, and pending counts are cleared. Upstream units are flushed by the same reset.

## Structure
- Package `gecko` gets:
  - `gecko_reg_status_t` (`logic [COUNTER_WIDTH-1:0]`);
  - `GECKO_REG_STATUS_VALID` (`'0`) and `GECKO_REG_STATUS_FULL` (`'1`);
  - `gecko_writeback_result_t` (packed: `rv32_reg_addr_t reg_addr`, `rv32_reg_value_t value`).
- `gecko_decode_reg_file_status_t` remains in `gecko_decode_util`.
- Sub-module `gecko_reg_scoreboard`:
  - contains the 32-counter array, increment/decrement/saturation logic and the error flag;
  - inputs: issue strobe/addr, retire strobe/addr;
  - outputs: status vector, error.
- `gecko_writeback` holds the arbiter, the output register stage and the scoreboard instance.

## Test plan
- **Reset:** hold `rst` 2 cycles → all 32 `reg_status` = 0, `rf_write_enable=0`, `scoreboard_error=0`.
- **Basic retire:** issue x5 at cycle 0 → `reg_status[5]=1` at cycle 1. `exec_valid`, x5, 0xDEADBEEF at cycle 3 → `exec_ready=1`; cycle 4 `rf_write_enable=1`, addr 5, value 0xDEADBEEF, `reg_status[5]=0`.
- **Priority:** `mem_valid`, `sys_valid` and `exec_valid` all high (x1, x2, x3 each pending 1) → order of writes: x1, x2, x3 on consecutive cycles. `exec_ready` stays 0 until the third cycle.
- **Same-register issue+retire:** x7 counter at 1, issue x7 and retire x7 in the same cycle → `reg_status[7]` stays 1, one write to x7, no error.
- **Saturation:** issue x9 three times → `reg_status[9]=3` (FULL). A fourth issue → stays 3 and `scoreboard_error=1`. Retire x9 with counter 0 on a fresh reset → no write, error=1.
- **x0 and reset:** `exec_valid` to x0 → `exec_ready=1`, no `rf_write_enable`. Assert `rst` the cycle after a mem transfer → no write the following cycle, counters 0.

Source files
------------

// File: rtl/gecko_writeback_pkg.sv
// Shared gecko core types used by the writeback stage and decode's
// register-status checks.
package gecko;

    localparam int GECKO_COUNTER_WIDTH = 2;

    typedef logic [4:0]  rv32_reg_addr_t;
    typedef logic [31:0] rv32_reg_value_t;

    typedef logic [GECKO_COUNTER_WIDTH-1:0] gecko_reg_status_t;

    localparam gecko_reg_status_t GECKO_REG_STATUS_VALID = '0;
    localparam gecko_reg_status_t GECKO_REG_STATUS_FULL  = '1;

    typedef struct packed {
        rv32_reg_addr_t  reg_addr;
        rv32_reg_value_t value;
    } gecko_writeback_result_t;

endpackage

package gecko_decode_util;

    import gecko::*;

    typedef gecko_reg_status_t [31:0] gecko_decode_reg_file_status_t;

endpackage

// File: rtl/gecko_writeback_if.sv
// Result handshakes from the execute, load and system units into writeback.
interface gecko_writeback_if;

    import gecko::*;

    logic                    exec_valid;
    logic                    exec_ready;
    gecko_writeback_result_t exec_result;

    logic                    mem_valid;
    logic                    mem_ready;
    gecko_writeback_result_t mem_result;

    logic                    sys_valid;
    logic                    sys_ready;
    gecko_writeback_result_t sys_result;

    modport master (
        output exec_valid, exec_result, mem_valid, mem_result, sys_valid, sys_result,
        input  exec_ready, mem_ready, sys_ready
    );

    modport slave (
        input  exec_valid, exec_result, mem_valid, mem_result, sys_valid, sys_result,
        output exec_ready, mem_ready, sys_ready
    );

endinterface

// File: rtl/gecko_reg_scoreboard.sv
// Per-register pending-write counters: reserved at issue, released at retire,
// saturating in both directions with a sticky error on any dropped update.
module gecko_reg_scoreboard
    import gecko::*;
#(
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid,
    input  rv32_reg_addr_t                issue_reg_addr,
    input  logic                          retire_valid,
    input  rv32_reg_addr_t                retire_reg_addr,
    output logic                          retire_accept,
    output logic [31:0][COUNTER_WIDTH-1:0] status,
    output logic                          error
);

    localparam logic [COUNTER_WIDTH-1:0] COUNT_FULL = '1;
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ZERO = '0;
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE  = COUNTER_WIDTH'(1);

    logic [COUNTER_WIDTH-1:0] counters [32];

    logic issue_hit;
    logic retire_hit;
    logic same_reg;
    logic issue_inc;
    logic retire_dec;
    logic error_set;

    // Issue and retire of the same register cancel out, even at 0 or FULL.
    always_comb begin
        issue_hit     = issue_valid && (issue_reg_addr != '0);
        retire_hit    = retire_valid && (retire_reg_addr != '0);
        same_reg      = issue_hit && retire_hit && (issue_reg_addr == retire_reg_addr);
        issue_inc     = issue_hit && !same_reg && (counters[issue_reg_addr] != COUNT_FULL);
        retire_dec    = retire_hit && !same_reg && (counters[retire_reg_addr] != COUNT_ZERO);
        retire_accept = same_reg || retire_dec;
        error_set     = (issue_hit && !same_reg && (counters[issue_reg_addr] == COUNT_FULL))
                     || (retire_hit && !same_reg && (counters[retire_reg_addr] == COUNT_ZERO));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                counters[i] <= COUNT_ZERO;
            end
            error <= 1'b0;
        end else begin
            if (issue_inc) begin
                counters[issue_reg_addr] <= counters[issue_reg_addr] + COUNT_ONE;
            end
            if (retire_dec) begin
                counters[retire_reg_addr] <= counters[retire_reg_addr] - COUNT_ONE;
            end
            error <= error | error_set;
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_status
        assign status[g] = counters[g];
    end

endmodule

// File: rtl/gecko_writeback.sv
// Writeback stage: fixed-priority result arbiter (mem > sys > exec), registered
// register-file write port and the pending-write scoreboard.
module gecko_writeback
    import gecko::*;
#(
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue_valid,
    input  rv32_reg_addr_t                 issue_reg_addr,
    gecko_writeback_if.slave               results,
    output logic                           rf_write_enable,
    output rv32_reg_addr_t                 rf_write_addr,
    output rv32_reg_value_t                rf_write_value,
    output logic [31:0][COUNTER_WIDTH-1:0] reg_status,
    output logic                           scoreboard_error
);

    logic                    xfer_valid;
    gecko_writeback_result_t xfer_result;
    logic                    write_accept;

    // Readies look only at higher-priority valids so each unit can rely on them.
    assign results.mem_ready  = 1'b1;
    assign results.sys_ready  = !results.mem_valid;
    assign results.exec_ready = !results.mem_valid && !results.sys_valid;

    always_comb begin
        xfer_valid  = 1'b0;
        xfer_result = '0;
        if (results.mem_valid) begin
            xfer_valid  = 1'b1;
            xfer_result = results.mem_result;
        end else if (results.sys_valid) begin
            xfer_valid  = 1'b1;
            xfer_result = results.sys_result;
        end else if (results.exec_valid) begin
            xfer_valid  = 1'b1;
            xfer_result = results.exec_result;
        end
    end

    gecko_reg_scoreboard #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_scoreboard (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_reg_addr  (issue_reg_addr),
        .retire_valid    (xfer_valid),
        .retire_reg_addr (xfer_result.reg_addr),
        .retire_accept   (write_accept),
        .status          (reg_status),
        .error           (scoreboard_error)
    );

    // A retire dropped by the scoreboard (x0 or unreserved) never reaches the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_value  <= '0;
        end else begin
            rf_write_enable <= write_accept;
            if (write_accept) begin
                rf_write_addr  <= xfer_result.reg_addr;
                rf_write_value <= xfer_result.value;
            end
        end
    end

endmodule

// File: tb/tb_gecko_writeback.sv
// Self-checking bench for gecko_writeback: arbitration table, directed corner
// sequences and randomized traffic against an integer-counter reference model.
module tb_gecko_writeback;

    import gecko::*;

    localparam int MAX_PENDING = 3;

    typedef struct packed {
        logic                    r;
        logic                    iv;
        rv32_reg_addr_t          ia;
        logic                    mv;
        gecko_writeback_result_t mres;
        logic                    sv;
        gecko_writeback_result_t sres;
        logic                    ev;
        gecko_writeback_result_t eres;
    } stim_t;

    typedef struct {
        logic mv, sv, ev;
        logic exp_m, exp_s, exp_e;
    } arb_vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid;
    rv32_reg_addr_t  issue_reg_addr;
    logic            rf_write_enable;
    rv32_reg_addr_t  rf_write_addr;
    rv32_reg_value_t rf_write_value;
    logic [31:0][1:0] reg_status;
    logic            scoreboard_error;

    gecko_writeback_if wb_if ();

    gecko_writeback dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid      (issue_valid),
        .issue_reg_addr   (issue_reg_addr),
        .results          (wb_if),
        .rf_write_enable  (rf_write_enable),
        .rf_write_addr    (rf_write_addr),
        .rf_write_value   (rf_write_value),
        .reg_status       (reg_status),
        .scoreboard_error (scoreboard_error)
    );

    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    int          model_cnt [32];
    bit          model_err;
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_val;

    arb_vec_t arb_tab [8];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of stimulus, advances the model, and checks everything.
    task automatic apply_stimulus(input stim_t s);
        bit          have;
        bit          same;
        int          wa;
        logic [31:0] wv;
        logic [63:0] exp_status;
        rst               = s.r;
        issue_valid       = s.iv;
        issue_reg_addr    = s.ia;
        wb_if.mem_valid   = s.mv;
        wb_if.mem_result  = s.mres;
        wb_if.sys_valid   = s.sv;
        wb_if.sys_result  = s.sres;
        wb_if.exec_valid  = s.ev;
        wb_if.exec_result = s.eres;
        #1;
        check_output("mem_ready",  64'(wb_if.mem_ready),  64'd1);
        check_output("sys_ready",  64'(wb_if.sys_ready),  64'(!s.mv));
        check_output("exec_ready", 64'(wb_if.exec_ready), 64'(!s.mv && !s.sv));

        have = 0;
        wa   = 0;
        wv   = '0;
        if (s.mv) begin
            have = 1; wa = int'(s.mres.reg_addr); wv = s.mres.value;
        end else if (s.sv) begin
            have = 1; wa = int'(s.sres.reg_addr); wv = s.sres.value;
        end else if (s.ev) begin
            have = 1; wa = int'(s.eres.reg_addr); wv = s.eres.value;
        end

        if (s.r) begin
            foreach (model_cnt[i]) model_cnt[i] = 0;
            model_err = 0;
            exp_we    = 0;
            exp_addr  = '0;
            exp_val   = '0;
        end else begin
            same   = have && s.iv && (wa != 0) && (wa == int'(s.ia));
            exp_we = 0;
            if (have && wa != 0) begin
                if (same) begin
                    exp_we = 1;
                end else if (model_cnt[wa] > 0) begin
                    model_cnt[wa]--;
                    exp_we = 1;
                end else begin
                    model_err = 1;
                end
                if (exp_we) begin
                    exp_addr = wa[4:0];
                    exp_val  = wv;
                end
            end
            if (s.iv && s.ia != 0 && !same) begin
                if (model_cnt[s.ia] == MAX_PENDING) model_err = 1;
                else model_cnt[s.ia]++;
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            exp_status[i*2 +: 2] = model_cnt[i][1:0];
        end
        check_output("rf_write_enable", 64'(rf_write_enable), 64'(exp_we));
        if (exp_we || s.r) begin
            check_output("rf_write_addr",  64'(rf_write_addr),  64'(exp_addr));
            check_output("rf_write_value", 64'(rf_write_value), 64'(exp_val));
        end
        check_output("reg_status", reg_status, exp_status);
        check_output("scoreboard_error", 64'(scoreboard_error), 64'(model_err));
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic do_reset();
        stim_t s;
        s   = idle_stim();
        s.r = 1'b1;
        apply_stimulus(s);
        apply_stimulus(s);
    endtask

    task automatic do_issue(input rv32_reg_addr_t a);
        stim_t s;
        s    = idle_stim();
        s.iv = 1'b1;
        s.ia = a;
        apply_stimulus(s);
    endtask

    initial begin
        stim_t s;
        tests_run    = 0;
        tests_failed = 0;
        foreach (model_cnt[i]) model_cnt[i] = 0;
        model_err = 0;
        exp_we    = 0;
        exp_addr  = '0;
        exp_val   = '0;

        arb_tab[0] = '{0, 0, 0, 1, 1, 1};
        arb_tab[1] = '{0, 0, 1, 1, 1, 1};
        arb_tab[2] = '{0, 1, 0, 1, 1, 0};
        arb_tab[3] = '{0, 1, 1, 1, 1, 0};
        arb_tab[4] = '{1, 0, 0, 1, 0, 0};
        arb_tab[5] = '{1, 0, 1, 1, 0, 0};
        arb_tab[6] = '{1, 1, 0, 1, 0, 0};
        arb_tab[7] = '{1, 1, 1, 1, 0, 0};

        do_reset();
        check_output("reset_we", 64'(rf_write_enable), 64'd0);
        check_output("reset_status", reg_status, 64'd0);

        // Readies are combinational and must follow the valids while in reset.
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wb_if.mem_valid  = arb_tab[i].mv;
            wb_if.sys_valid  = arb_tab[i].sv;
            wb_if.exec_valid = arb_tab[i].ev;
            #1;
            check_output($sformatf("arb%0d_mem", i),  64'(wb_if.mem_ready),  64'(arb_tab[i].exp_m));
            check_output($sformatf("arb%0d_sys", i),  64'(wb_if.sys_ready),  64'(arb_tab[i].exp_s));
            check_output($sformatf("arb%0d_exec", i), 64'(wb_if.exec_ready), 64'(arb_tab[i].exp_e));
            @(posedge clk);
            #1;
        end
        do_reset();

        // Basic retire of x5.
        do_issue(5'd5);
        check_output("basic_pending5", 64'(reg_status[5]), 64'd1);
        apply_stimulus(idle_stim());
        apply_stimulus(idle_stim());
        s      = idle_stim();
        s.ev   = 1'b1;
        s.eres = '{5'd5, 32'hDEADBEEF};
        apply_stimulus(s);
        check_output("basic_we",     64'(rf_write_enable), 64'd1);
        check_output("basic_addr",   64'(rf_write_addr),   64'd5);
        check_output("basic_value",  64'(rf_write_value),  64'hDEADBEEF);
        check_output("basic_status", 64'(reg_status[5]),   64'd0);

        // Priority: all three present, each unit holds valid until accepted.
        do_issue(5'd1);
        do_issue(5'd2);
        do_issue(5'd3);
        s      = idle_stim();
        s.mv   = 1'b1; s.mres = '{5'd1, 32'h1111_1111};
        s.sv   = 1'b1; s.sres = '{5'd2, 32'h2222_2222};
        s.ev   = 1'b1; s.eres = '{5'd3, 32'h3333_3333};
        apply_stimulus(s);
        check_output("prio_first", 64'(rf_write_addr), 64'd1);
        s.mv = 1'b0;
        apply_stimulus(s);
        check_output("prio_second", 64'(rf_write_addr), 64'd2);
        s.sv = 1'b0;
        apply_stimulus(s);
        check_output("prio_third", 64'(rf_write_addr), 64'd3);

        // Same-register issue and retire in one cycle.
        do_issue(5'd7);
        s      = idle_stim();
        s.iv   = 1'b1; s.ia = 5'd7;
        s.ev   = 1'b1; s.eres = '{5'd7, 32'h0000_7777};
        apply_stimulus(s);
        check_output("same_status", 64'(reg_status[7]),   64'd1);
        check_output("same_we",     64'(rf_write_enable), 64'd1);
        check_output("same_err",    64'(scoreboard_error), 64'd0);

        // Saturation on issue, then retire to an empty counter.
        do_issue(5'd9);
        do_issue(5'd9);
        do_issue(5'd9);
        check_output("sat_full", 64'(reg_status[9]), 64'd3);
        check_output("sat_noerr", 64'(scoreboard_error), 64'd0);
        do_issue(5'd9);
        check_output("sat_hold", 64'(reg_status[9]), 64'd3);
        check_output("sat_err",  64'(scoreboard_error), 64'd1);
        do_reset();
        s      = idle_stim();
        s.ev   = 1'b1; s.eres = '{5'd9, 32'h9999_9999};
        apply_stimulus(s);
        check_output("empty_retire_we",  64'(rf_write_enable), 64'd0);
        check_output("empty_retire_err", 64'(scoreboard_error), 64'd1);

        // x0 retire is consumed silently; reset discards an in-flight write.
        do_reset();
        s      = idle_stim();
        s.ev   = 1'b1; s.eres = '{5'd0, 32'hABCD_0000};
        apply_stimulus(s);
        check_output("x0_we", 64'(rf_write_enable), 64'd0);
        do_issue(5'd4);
        s      = idle_stim();
        s.mv   = 1'b1; s.mres = '{5'd4, 32'h4444_4444};
        apply_stimulus(s);
        s      = idle_stim();
        s.r    = 1'b1;
        apply_stimulus(s);
        check_output("rst_mid_we",     64'(rf_write_enable), 64'd0);
        check_output("rst_mid_status", reg_status, 64'd0);
        apply_stimulus(idle_stim());

        // Randomized traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            s      = idle_stim();
            s.r    = ($urandom_range(0, 59) == 0);
            s.iv   = $urandom_range(0, 1) == 1;
            s.ia   = 5'($urandom_range(0, 8));
            s.mv   = ($urandom_range(0, 3) == 0);
            s.mres = '{5'($urandom_range(0, 8)), 32'($urandom)};
            s.sv   = ($urandom_range(0, 3) == 0);
            s.sres = '{5'($urandom_range(0, 8)), 32'($urandom)};
            s.ev   = ($urandom_range(0, 2) == 0);
            s.eres = '{5'($urandom_range(0, 8)), 32'($urandom)};
            apply_stimulus(s);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
